// File: rtl/bitbakery_input_pkg.sv
// Shared definitions for the BitBakery input conditioner: channel-state
// encoding, channel map and the counter-width helper.
// Optional feature macro used by the slice: BITBAKERY_AUTO_REPEAT_EN.
package bitbakery_input_pkg;

    typedef enum logic [1:0] {
        SOLTO          = 2'b00,
        CONFIRMA_PRESS = 2'b01,
        PRESSIONADO    = 2'b10,
        CONFIRMA_SOLTA = 2'b11
    } chan_state_e;

    localparam int NUM_CHANNELS  = 8;
    localparam int NUM_BUTTONS   = 7;
    localparam int START_CHANNEL = 7;

    // Width able to hold the largest of the three cycle counts.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bitbakery_input_conditioner_if.sv
// Board-side button bus of the input conditioner.
// master: board/bench side, slave: the conditioner.
interface bitbakery_input_conditioner_if;
    import bitbakery_input_pkg::*;

    logic                   enable;
    logic [NUM_BUTTONS-1:0] botoes_in;
    logic                   iniciar_in;
    logic [NUM_BUTTONS-1:0] botoes;
    logic [NUM_BUTTONS-1:0] botoes_pulso;
    logic                   iniciar;
    logic                   algum_botao;
    logic [2:0]             codigo_botao;

    modport master (
        output enable, botoes_in, iniciar_in,
        input  botoes, botoes_pulso, iniciar, algum_botao, codigo_botao
    );

    modport slave (
        input  enable, botoes_in, iniciar_in,
        output botoes, botoes_pulso, iniciar, algum_botao, codigo_botao
    );

endinterface

// File: rtl/bitbakery_input_conditioner_debounce_channel.sv
// One input channel: inversion, 2-FF synchroniser, debounce FSM with
// saturating counter, registered level and press pulse.
// With BITBAKERY_AUTO_REPEAT_EN defined, REPEAT_EN channels also emit
// auto-repeat pulses while held.
module debounce_channel
    import bitbakery_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 150
`ifdef BITBAKERY_AUTO_REPEAT_EN
    , parameter bit REPEAT_EN     = 1'b1
`endif
) (
    input  logic clock,
    input  logic reset_in,
    input  logic raw_n,
    input  logic enable,
    output logic level,
    output logic pulse
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic             sync1, sync2;
    chan_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_evt;
    logic             pulse_evt;

    // Synchroniser on the inverted (active-high) raw input.
    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            // NOTE: non-blocking so sync2 takes the old sync1, giving two real stages.
            sync1 <= ~raw_n;
            sync2 <= sync1;
        end
    end

    // Debounce state and counter registers.
    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            state <= SOLTO;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: a level change is accepted after DEBOUNCE_CYCLES equal samples.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch forms.
        state_nxt = state;
        cnt_nxt   = cnt;
        press_evt = 1'b0;
        unique case (state)
            SOLTO: begin
                if (sync2) begin
                    state_nxt = CONFIRMA_PRESS;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            CONFIRMA_PRESS: begin
                if (!sync2) begin
                    state_nxt = SOLTO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                    if (cnt >= DEB_LAST) begin
                        state_nxt = PRESSIONADO;
                        press_evt = 1'b1;
                    end
                end
            end
            PRESSIONADO: begin
                if (!sync2) begin
                    state_nxt = CONFIRMA_SOLTA;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            CONFIRMA_SOLTA: begin
                if (sync2) begin
                    state_nxt = PRESSIONADO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = sat_inc(cnt);
                    if (cnt >= DEB_LAST) state_nxt = SOLTO;
                end
            end
            default: state_nxt = SOLTO;
        endcase
    end

`ifdef BITBAKERY_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rpt_cnt;
    logic             rpt_after_first;
    logic             rpt_hold;
    logic             rpt_evt;

    // Repeat fires after REPEAT_DELAY on the first repeat, REPEAT_PERIOD afterwards.
    always_comb begin
        rpt_hold = (state == PRESSIONADO) && (state_nxt == PRESSIONADO);
        rpt_evt  = REPEAT_EN && rpt_hold &&
                   (rpt_cnt == (rpt_after_first ? RP_LAST : RD_LAST));
    end

    // Repeat counter: cleared on entry to PRESSIONADO, frozen outside it.
    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) begin
            rpt_cnt         <= '0;
            rpt_after_first <= 1'b0;
        end else if (state_nxt == PRESSIONADO && state != PRESSIONADO) begin
            rpt_cnt         <= '0;
            rpt_after_first <= 1'b0;
        end else if (rpt_evt) begin
            rpt_cnt         <= '0;
            rpt_after_first <= 1'b1;
        end else if (rpt_hold) begin
            rpt_cnt <= sat_inc(rpt_cnt);
        end
    end

    assign pulse_evt = press_evt | rpt_evt;
`else
    assign pulse_evt = press_evt;
`endif

    // Registered pulse, masked while disabled.
    always_ff @(posedge clock or negedge reset_in) begin
        if (!reset_in) pulse <= 1'b0;
        else           pulse <= enable & pulse_evt;
    end

    assign level = (state == PRESSIONADO) || (state == CONFIRMA_SOLTA);

endmodule

// File: rtl/bitbakery_input_conditioner.sv
// BitBakery input conditioner top: eight debounce channels (buttons 0..6
// and the start button), OR of the button levels and a priority encoder.
// Optional feature macro: BITBAKERY_AUTO_REPEAT_EN (buttons 0..6 only).
module bitbakery_input_conditioner
    import bitbakery_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 150
) (
    input  logic                          clock,
    input  logic                          reset_in,
    bitbakery_input_conditioner_if.slave  bus
);

    logic [NUM_CHANNELS-1:0] raw_n;
    logic [NUM_CHANNELS-1:0] lvl;
    logic [NUM_CHANNELS-1:0] pls;
    logic [2:0]              codigo;

    assign raw_n = {bus.iniciar_in, bus.botoes_in};

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
`ifdef BITBAKERY_AUTO_REPEAT_EN
            , .REPEAT_EN    (k != START_CHANNEL)
`endif
        ) u_chan (
            .clock   (clock),
            .reset_in(reset_in),
            .raw_n   (raw_n[k]),
            .enable  (bus.enable),
            .level   (lvl[k]),
            .pulse   (pls[k])
        );
    end

    // Lowest-numbered pressed button wins; 0 when nothing is held.
    always_comb begin
        codigo = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (lvl[i]) codigo = 3'(i);
        end
    end

    assign bus.botoes       = lvl[NUM_BUTTONS-1:0];
    assign bus.botoes_pulso = pls[NUM_BUTTONS-1:0];
    // A start pulse only ever coincides with the start level being set.
    assign bus.iniciar      = pls[START_CHANNEL] & lvl[START_CHANNEL];
    assign bus.algum_botao  = |lvl[NUM_BUTTONS-1:0];
    assign bus.codigo_botao = codigo;

endmodule

// File: doc/bitbakery_input_conditioner.md
Name: bitbakery_input_conditioner

Overview:
- Upstream conditioning stage for the BitBakery top: takes the raw active-low pushbuttons `botoes_in[6:0]` and `iniciar_in` straight from the board pins.
- Synchronises, debounces and edge-detects each channel.
- Delivers clean active-high levels and single-cycle press pulses to the minigames and the top FSM.
- Runs on the divided game clock (nominal 1 kHz, so one cycle ≈ 1 ms).

Parameters:
- DEBOUNCE_CYCLES, 20: consecutive stable synchronised samples required to accept a level change (≥2).
- REPEAT_DELAY, 500: cycles a button must be held before the first auto-repeat pulse (only with AUTO_REPEAT_EN).
- REPEAT_PERIOD, 150: cycles between subsequent auto-repeat pulses (only with AUTO_REPEAT_EN).

Ports:
- clock  in  1  game clock; all state updates on rising edge.
- reset_in  in  1  asynchronous, active-low reset.
- enable  in  1  when 0, pulse outputs are forced to 0; levels still track.
- botoes_in  in  7  raw buttons, active-low, asynchronous.
- iniciar_in  in  1  raw start button, active-low, asynchronous.
- botoes  out  7  debounced level, active-high.
- botoes_pulso  out  7  one-cycle pulse on accepted press (and on repeat).
- iniciar  out  1  one-cycle pulse on accepted press of the start button.
- algum_botao  out  1  OR of `botoes`.
- codigo_botao  out  3  index of the lowest-numbered button currently set in `botoes`; 0 when none.

Behaviour:
- Channel layout: 8 identical channels. Channel k (0..6) is `botoes_in[k]`; channel 7 is `iniciar_in`. Each channel inverts its input, then passes it through a 2-FF synchroniser (reset value 0 = released).
- Channel FSM states:
  - SOLTO: accepted level 0.
  - CONFIRMA_PRESS: sync=1 seen; counting.
  - PRESSIONADO: accepted level 1.
  - CONFIRMA_SOLTA: sync=0 seen; counting.
- Transitions:
  - SOLTO→CONFIRMA_PRESS on sync=1; counter cleared to 1.
  - CONFIRMA_PRESS: sync=1 increments the counter. When the counter reaches DEBOUNCE_CYCLES → PRESSIONADO and a pulse is emitted that same cycle. sync=0 → back to SOLTO, with no pulse.
  - PRESSIONADO→CONFIRMA_SOLTA on sync=0; counter cleared to 1.
  - CONFIRMA_SOLTA: sync=0 increments the counter. Reaching DEBOUNCE_CYCLES → SOLTO. sync=1 → PRESSIONADO, with no second pulse.
- Level output is 1 in PRESSIONADO and CONFIRMA_SOLTA, and 0 otherwise.
- Latency: from a clean raw edge to the level/pulse is 2 sync cycles + DEBOUNCE_CYCLES cycles; outputs are registered.
- A pulse lasts exactly one cycle. Each accepted press gives exactly one pulse, regardless of hold length (without AUTO_REPEAT_EN).
- Bounce rule: a glitch shorter than DEBOUNCE_CYCLES never changes the level and never pulses.
- `enable`=0:
  - Pulses are masked to 0; the FSM keeps running.
  - If `enable` rises while a button is held, no retroactive pulse is emitted.
- Channel independence: simultaneous presses on several channels each pulse in the same cycle.
- `codigo_botao` is a priority encode of `botoes` (bit 0 highest priority), computed combinationally from the registered levels.
- Counter saturation: width = clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1); the counter saturates and never wraps.
- Reset: `reset_in`=0 immediately forces all synchronisers to 0, all FSMs to SOLTO, all counters to 0, and all outputs to 0.
  - A button held through reset release must complete full debounce before pulsing; it pulses exactly once.

Optional Feature:
- Macro: BITBAKERY_AUTO_REPEAT_EN.
- When defined, channels 0..6 only:
  - After REPEAT_DELAY cycles in PRESSIONADO, one extra pulse is emitted.
  - Further pulses follow every REPEAT_PERIOD cycles while the button stays in PRESSIONADO.
  - The repeat counter resets on entry to PRESSIONADO and is held during CONFIRMA_SOLTA.
  - Returning from CONFIRMA_SOLTA to PRESSIONADO restarts REPEAT_DELAY.
  - Channel 7 (`iniciar`) never repeats.
- When undefined: no repeat logic is synthesised, and exactly one pulse per press.

Decomposition:
- Package bitbakery_input_pkg: channel-state encoding constants (SOLTO=2'b00, CONFIRMA_PRESS=2'b01, PRESSIONADO=2'b10, CONFIRMA_SOLTA=2'b11), the channel count (8), and the index of the start channel (7).
- Sub-module debounce_channel holds one synchroniser, FSM, counter and optional repeat logic, with ports clock, reset_in, raw_n, enable, level, pulse. The top instantiates it 8 times and adds the OR and the priority encoder.

Test Plan:
- Reset/idle: `reset_in`=0, then release with all raw=1 → all outputs 0 for 100 cycles.
- Clean press: `botoes_in[3]` held 0 from cycle 10 → `botoes[3]`=1 and `botoes_pulso[3]` high exactly at cycle 32 only; `codigo_botao`=3; `algum_botao`=1.
- Bounce: `botoes_in[0]` toggled 0/1 every 5 cycles for 60 cycles, then held 0 → a single pulse 22 cycles after the final stable edge, none before.
- Simultaneous: `botoes_in[1]` and `botoes_in[5]` fall on the same cycle → both pulse on the same cycle; `codigo_botao`=1.
- Enable and start: `enable`=0 during the `iniciar_in` press → `iniciar` stays 0. Release, set `enable`=1, press again → `iniciar` pulses once 22 cycles later.
- Repeat (macro defined) and mid-operation reset:
  - `botoes_in[2]` held 1000 cycles → pulses at +22, +522, +672, +822, +972.
  - Assert `reset_in` mid-hold → outputs go 0 immediately; after reset release a single pulse follows 22 cycles later.
